rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file: drives its write-enable, write address and write data.
- After every reset, sequences a clear sweep that zeroes registers 1..31.
- Then shares the write port among NREQ writeback requesters (ALU, load unit, input device) using valid/ready handshakes and round-robin arbitration.
- Sits between the execute/memory/IO writeback sources and the register file.

Parameters:
NREQ, 3, number of writeback requesters (2..4)
ADDR_W, 5, register address width
DATA_W, 32, register data width
NREGS, 32, number of registers swept at init (register 0 excluded)

Ports:
clock  in  1  system clock, all state changes on posedge
reset  in  1  synchronous, active-high
req_valid  in  NREQ  per-requester write request
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_addr  in  NREQ*ADDR_W  packed destination addresses, requester i at bits [i*ADDR_W +: ADDR_W]
req_data  in  NREQ*DATA_W  packed write data, same packing
rf_flag  out  1  register-file write enable
rf_addr  out  ADDR_W  register-file write address
rf_data  out  DATA_W  register-file write data
grant_id  out  2  index of the requester whose write is on rf_* this cycle
init_busy  out  1  high while the clear sweep runs

Behaviour:
- FSM states: INIT, RUN.
- Reset (synchronous, active-high) has priority over all else. It forces:
  - state=INIT, sweep counter=1, rr pointer=0;
  - rf_flag=0, rf_addr=0, rf_data=0, grant_id=0;
  - init_busy=1, req_ready=0.
- INIT:
  - Each cycle the registered outputs load rf_flag=1, rf_addr=counter, rf_data=0; counter then increments.
  - When counter==NREGS-1 is issued, next state is RUN.
  - The sweep issues 31 writes, to registers 1..31 in order.
  - init_busy is high throughout INIT and falls in the first RUN cycle.
  - req_ready=0 for the whole of INIT.
- RUN, arbitration (combinational, same cycle):
  - Scan requesters starting at the rr pointer, wrapping modulo NREQ.
  - The first one with req_valid=1 wins and receives req_ready=1; all others get 0.
  - If no requester is valid, req_ready=0 and the pointer is unchanged.
- RUN, acceptance: a handshake (valid & ready) in cycle N produces on cycle N+1:
  - rf_flag=1, rf_addr and rf_data = the winner's addr/data, grant_id = the winner index;
  - rr pointer = (winner+1) mod NREQ.
  - Write latency is fixed at 1 cycle; throughput is 1 write per cycle.
- No acceptance in cycle N means rf_flag=0 in N+1. rf_addr, rf_data and grant_id hold their last values.
- Address 0: the request is accepted (ready=1, pointer advances), but rf_flag=0 in N+1. Register 0 is never written by this block.
- Handshake rule: a requester keeps valid, addr and data stable until it sees ready. The arbiter never grants a requester whose valid is low.
- Reset asserted mid-RUN:
  - An outstanding (not yet readied) request is not accepted.
  - A write accepted in the same cycle reset is asserted is discarded (rf_flag=0 next cycle).
  - The sweep restarts from register 1.
- Reset asserted mid-INIT: the sweep restarts from register 1.
- Counter and pointer widths: counter ADDR_W bits; pointer clog2(NREQ) bits, wrapping explicitly at NREQ, not at a power of 2.

Optional Feature:
- Macro: RFARB_FIXED_PRIO_EN.
- Defined: the rr pointer is removed and fixed priority applies, requester 0 highest. The lowest-index valid requester is always granted.
- Undefined: round-robin as described above.
- INIT behaviour and latency are identical in both builds.

Decomposition:
- Shared package holds:
  - ADDR_W, DATA_W, NREGS constants;
  - requester index constants: REQ_ALU=0, REQ_LOAD=1, REQ_IO=2;
  - FSM state encoding: INIT=0, RUN=1.
- One natural sub-module, rr_arbiter: NREQ-wide priority scan from the pointer, producing a one-hot grant and the winner index. It is parameterised by NREQ and honours RFARB_FIXED_PRIO_EN.

Test Plan:
- Reset for 2 cycles then release -> 31 consecutive cycles of rf_flag=1 with rf_addr=1..31 and rf_data=0; init_busy falls after the r31 write; req_ready=0 throughout.
- In RUN, requester 1 alone valid with addr=5, data=0xDEADBEEF -> req_ready=3'b010 that cycle; next cycle rf_flag=1, rf_addr=5, rf_data=0xDEADBEEF, grant_id=1.
- All three valid continuously for 6 cycles (pointer=0) -> grant_id sequence 0,1,2,0,1,2; rf_flag=1 every cycle.
- Requester 2 valid with addr=0, data=0x1234 -> ready asserted, rf_flag=0 next cycle; a following requester 0 is granted next (pointer advanced to 0).
- Reset during RUN while requester 0 is valid and unreadied -> no write of its data; the sweep restarts at rf_addr=1; its request is granted only after INIT completes.
- With RFARB_FIXED_PRIO_EN defined and all three valid for 4 cycles -> grant_id 0,0,0,0; requester 2 is granted only once 0 and 1 drop valid.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants, requester indices and FSM encoding for the register-file write arbiter.
package rf_write_arbiter_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 32;

  localparam int unsigned REQ_ALU  = 0;
  localparam int unsigned REQ_LOAD = 1;
  localparam int unsigned REQ_IO   = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

  // Round-robin successor, wrapping at n rather than at a power of two.
  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// NREQ-wide priority scan starting at a pointer; one-hot grant plus winner index.
// RFARB_FIXED_PRIO_EN: ignore the pointer, requester 0 always highest priority.
module rr_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic             en_i,
  input  logic [NREQ-1:0]  valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [1:0]       idx_o,
  output logic             found_o
);

  int unsigned base;
  int unsigned pos;

`ifdef RFARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
  assign base = 0;
`else
  assign base = 32'(ptr_i);
`endif

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (base + k) % NREQ;
      if (en_i && !found_o && valid_i[pos]) begin
        found_o      = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = 2'(pos);
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: clear sweep of r1..r31 after reset, then
// round-robin (or fixed priority with RFARB_FIXED_PRIO_EN) sharing among requesters.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = rf_write_arbiter_pkg::ADDR_W,
  parameter int unsigned DATA_W = rf_write_arbiter_pkg::DATA_W,
  parameter int unsigned NREGS  = rf_write_arbiter_pkg::NREGS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic                     rf_flag,
  output logic [ADDR_W-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_data,
  output logic [1:0]               grant_id,
  output logic                     init_busy
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  rf_state_e         state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              rf_flag_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_data_q;
  logic [1:0]        grant_id_q;
  logic              init_busy_q;
  logic [PTR_W-1:0]  arb_ptr;

`ifdef RFARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [PTR_W-1:0] ptr_q;
  assign arb_ptr = ptr_q;
`endif

  logic              arb_en;
  logic [NREQ-1:0]   arb_grant;
  logic [1:0]        win_idx;
  logic              win_found;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Reset suppresses the handshake so a pending request stays with its owner.
  assign arb_en = (state_q == RUN) && !reset;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .en_i    (arb_en),
    .valid_i (req_valid),
    .ptr_i   (arb_ptr),
    .grant_o (arb_grant),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  assign req_ready = arb_grant;

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (32'(win_idx) == i) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT;
      cnt_q       <= ADDR_W'(1);
      rf_flag_q   <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      grant_id_q  <= '0;
      init_busy_q <= 1'b1;
`ifndef RFARB_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      case (state_q)
        INIT: begin
          rf_flag_q <= 1'b1;
          rf_addr_q <= cnt_q;
          rf_data_q <= '0;
          cnt_q     <= cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(NREGS - 1)) begin
            state_q     <= RUN;
            init_busy_q <= 1'b0;
          end
        end
        RUN: begin
          if (win_found) begin
            // Writes to r0 are accepted but never reach the register file.
            rf_flag_q  <= (win_addr != '0);
            rf_addr_q  <= win_addr;
            rf_data_q  <= win_data;
            grant_id_q <= win_idx;
`ifndef RFARB_FIXED_PRIO_EN
            ptr_q      <= PTR_W'(rr_next(32'(win_idx), NREQ));
`endif
          end else begin
            rf_flag_q <= 1'b0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign rf_flag   = rf_flag_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;
  assign grant_id  = grant_id_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a behavioural model checked every cycle.
// Build with RFARB_FIXED_PRIO_EN to exercise the fixed-priority variant.
module tb_rf_write_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NR   = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              rf_flag;
  logic [AW-1:0]     rf_addr;
  logic [DW-1:0]     rf_data;
  logic [1:0]        grant_id;
  logic              init_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  rf_write_arbiter #(
    .NREQ   (NREQ),
    .ADDR_W (AW),
    .DATA_W (DW),
    .NREGS  (NR)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_flag   (rf_flag),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .grant_id  (grant_id),
    .init_busy (init_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_live = 0;
  int          m_sweep;      // next register the clear sweep writes; 0 once running
  int          m_ptr;
  bit          e_flag;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic [1:0]  e_gid;
  bit          e_busy;
  bit          e_known;      // addr/data/gid predictable (not after an r0 accept)

  function automatic int model_winner(input logic [NREQ-1:0] v, input int ptr);
    int start;
`ifdef RFARB_FIXED_PRIO_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < NREQ; k++)
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clock) begin
    int w;
    if (reset) begin
      m_live = 1; m_sweep = 1; m_ptr = 0;
      e_flag = 0; e_addr = 0; e_data = 0; e_gid = 0; e_busy = 1; e_known = 1;
    end else if (m_live) begin
      if (m_sweep != 0) begin
        e_flag = 1; e_addr = 5'(m_sweep); e_data = 0; e_known = 1;
        if (m_sweep == NR - 1) begin m_sweep = 0; e_busy = 0; end
        else m_sweep++;
      end else begin
        w = model_winner(req_valid, m_ptr);
        if (w >= 0) begin
          e_addr  = req_addr[w*AW +: AW];
          e_data  = req_data[w*DW +: DW];
          e_gid   = 2'(w);
          e_flag  = (e_addr != 0);
          e_known = e_flag;
          m_ptr   = (w + 1) % NREQ;
        end else begin
          e_flag = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    int w;
    logic [NREQ-1:0] e_ready;
    if (m_live) begin
      chk("m_flag", 32'(rf_flag), 32'(e_flag));
      chk("m_busy", 32'(init_busy), 32'(e_busy));
      if (e_known) begin
        chk("m_addr", 32'(rf_addr), 32'(e_addr));
        chk("m_data", rf_data, e_data);
        chk("m_gid", 32'(grant_id), 32'(e_gid));
      end
      if (!reset) begin
        e_ready = '0;
        if (m_sweep == 0) begin
          w = model_winner(req_valid, m_ptr);
          if (w >= 0) e_ready[w] = 1'b1;
        end
        chk("m_ready", 32'(req_ready), 32'(e_ready));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic sweep_check();
    for (int i = 1; i <= 31; i++) begin
      tick(); #1;
      chk("sweep_flag", 32'(rf_flag), 32'd1);
      chk("sweep_addr", 32'(rf_addr), 32'(i));
      chk("sweep_data", rf_data, 32'd0);
      chk("sweep_busy", 32'(init_busy), (i < 31) ? 32'd1 : 32'd0);
      if (i < 31) chk("sweep_ready", 32'(req_ready), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    tick(); tick();
    reset = 1'b0; #1;
    chk("rst_flag", 32'(rf_flag), 32'd0);
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_addr", 32'(rf_addr), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    sweep_check();
    tick(); #1;
    chk("idle_flag", 32'(rf_flag), 32'd0);

    // Requester 1 alone
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF); #1;
    chk("r1_ready", 32'(req_ready), 32'b010);
    tick(); set_req(1, 1'b0, 5'd0, 32'd0); #1;
    chk("r1_flag", 32'(rf_flag), 32'd1);
    chk("r1_addr", 32'(rf_addr), 32'd5);
    chk("r1_data", rf_data, 32'hDEADBEEF);
    chk("r1_gid", 32'(grant_id), 32'd1);
    tick(); #1;
    chk("hold_flag", 32'(rf_flag), 32'd0);
    chk("hold_addr", 32'(rf_addr), 32'd5);
    chk("hold_data", rf_data, 32'hDEADBEEF);

    // Requester 2 writes r0: accepted, no write
    set_req(2, 1'b1, 5'd0, 32'h1234); #1;
    chk("r0_ready", 32'(req_ready), 32'b100);
    tick(); set_req(2, 1'b0, 5'd0, 32'd0); #1;
    chk("r0_flag", 32'(rf_flag), 32'd0);

    // All three continuously valid
    set_req(0, 1'b1, 5'd10, 32'h100);
    set_req(1, 1'b1, 5'd11, 32'h101);
    set_req(2, 1'b1, 5'd12, 32'h102);
`ifdef RFARB_FIXED_PRIO_EN
    for (int j = 0; j < 4; j++) begin
      tick(); #1;
      chk("fp_flag", 32'(rf_flag), 32'd1);
      chk("fp_gid", 32'(grant_id), 32'd0);
    end
    set_req(0, 1'b0, 5'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 32'd0); #1;
    chk("fp_ready2", 32'(req_ready), 32'b100);
    tick(); #1;
    chk("fp_gid2", 32'(grant_id), 32'd2);
    chk("fp_addr2", 32'(rf_addr), 32'd12);
`else
    for (int j = 0; j < 6; j++) begin
      tick(); #1;
      chk("rr_flag", 32'(rf_flag), 32'd1);
      chk("rr_gid", 32'(grant_id), 32'(j % 3));
      chk("rr_addr", 32'(rf_addr), 32'(10 + j % 3));
    end
`endif
    req_valid = '0;
    tick(); #1;
    chk("drain_flag", 32'(rf_flag), 32'd0);

    // Reset mid-RUN with requester 0 pending
    set_req(0, 1'b1, 5'd7, 32'hA5A5A5A5);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("rr_rst_flag", 32'(rf_flag), 32'd0);
    chk("rr_rst_busy", 32'(init_busy), 32'd1);
    sweep_check();
    chk("post_ready", 32'(req_ready), 32'b001);
    tick(); set_req(0, 1'b0, 5'd0, 32'd0); #1;
    chk("post_flag", 32'(rf_flag), 32'd1);
    chk("post_addr", 32'(rf_addr), 32'd7);
    chk("post_data", rf_data, 32'hA5A5A5A5);
    chk("post_gid", 32'(grant_id), 32'd0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
